// File: rtl/rtc_bus_arbiter_if.sv
// rtl/rtc_bus_arbiter_if.sv - Acceso/Dir/FRW handshake bundle between the arbiter and the RTC driver
interface rtc_bus_arbiter_if #(
   parameter int ADDR_W = 8
);
   logic              Acceso;
   logic [ADDR_W-1:0] Dir;
   logic              WR;
   logic [7:0]        Dato_out;
   logic [7:0]        Dato_in;
   logic              FRW;

   modport master (output Acceso, Dir, WR, Dato_out, input Dato_in, FRW);
   modport slave  (input Acceso, Dir, WR, Dato_out, output Dato_in, FRW);
endinterface

// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - fixed-priority arbiter sharing one RTC read/write driver among requesters
// Optional RTC_CMD_F0_EN chains an F0 (RAM-to-RTC transfer) write after every successful write.
module rtc_bus_arbiter #(
   parameter int REQ_N   = 3,
   parameter int ADDR_W  = 8,
   parameter int ACC_CYC = 7,
   parameter int TIMEOUT = 255
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [REQ_N-1:0]          req,
   input  logic [REQ_N-1:0]          req_wr,
   input  logic [REQ_N*ADDR_W-1:0]   req_dir,
   input  logic [REQ_N*8-1:0]        req_wdata,
   output logic [REQ_N-1:0]          gnt,
   output logic [REQ_N-1:0]          done,
   output logic                      err,
   output logic [7:0]                rdata,
   rtc_bus_arbiter_if.master         bus
);
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ISSUE     = 3'd1;
   localparam logic [2:0] S_WAIT      = 3'd2;
   localparam logic [2:0] S_DONE      = 3'd3;
`ifdef RTC_CMD_F0_EN
   localparam logic [2:0] S_CMD_ISSUE = 3'd4;
   localparam logic [2:0] S_CMD_WAIT  = 3'd5;
`endif
   localparam logic [3:0] ACC_LAST = 4'(ACC_CYC);
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

   logic [2:0]        state;
   logic [3:0]        acc_cnt;
   logic [7:0]        wait_cnt;
   logic              acceso_q;
   logic [ADDR_W-1:0] dir_q;
   logic              wr_q;
   logic [7:0]        dout_q;

   logic [REQ_N-1:0]  pick;
   logic [ADDR_W-1:0] sel_dir;
   logic              sel_wr;
   logic [7:0]        sel_wd;

   // Scan from the top index down so the lowest set request wins.
   always_comb begin
      pick    = '0;
      sel_dir = '0;
      sel_wr  = 1'b0;
      sel_wd  = '0;
      for (int i = REQ_N - 1; i >= 0; i--) begin
         if (req[i]) begin
            pick    = '0;
            pick[i] = 1'b1;
            sel_dir = req_dir[i*ADDR_W +: ADDR_W];
            sel_wr  = req_wr[i];
            sel_wd  = req_wdata[i*8 +: 8];
         end
      end
   end

   assign bus.Acceso   = acceso_q;
   assign bus.Dir      = dir_q;
   assign bus.WR       = wr_q;
   assign bus.Dato_out = dout_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         gnt      <= '0;
         done     <= '0;
         err      <= 1'b0;
         rdata    <= 8'h00;
         acceso_q <= 1'b0;
         dir_q    <= '0;
         wr_q     <= 1'b0;
         dout_q   <= 8'h00;
         acc_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         done <= '0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  gnt      <= pick;
                  dir_q    <= sel_dir;
                  wr_q     <= sel_wr;
                  dout_q   <= sel_wd;
                  acceso_q <= 1'b1;
                  acc_cnt  <= 4'd1;
                  wait_cnt <= '0;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (acc_cnt == ACC_LAST) begin
                  acceso_q <= 1'b0;
                  state    <= S_WAIT;
               end else begin
                  acc_cnt <= acc_cnt + 4'd1;
               end
            end
            S_WAIT: begin
               if (bus.FRW) begin
                  if (!wr_q) rdata <= bus.Dato_in;
`ifdef RTC_CMD_F0_EN
                  if (wr_q) begin
                     dir_q    <= ADDR_W'(8'hF0);
                     dout_q   <= 8'hF0;
                     acceso_q <= 1'b1;
                     acc_cnt  <= 4'd1;
                     wait_cnt <= '0;
                     state    <= S_CMD_ISSUE;
                  end else begin
                     done  <= gnt;
                     state <= S_DONE;
                  end
`else
                  done  <= gnt;
                  state <= S_DONE;
`endif
               end else if (wait_cnt == TO_LAST) begin
                  done  <= gnt;
                  err   <= 1'b1;
                  state <= S_DONE;
               end else if (wait_cnt != 8'hFF) begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
`ifdef RTC_CMD_F0_EN
            S_CMD_ISSUE: begin
               if (acc_cnt == ACC_LAST) begin
                  acceso_q <= 1'b0;
                  state    <= S_CMD_WAIT;
               end else begin
                  acc_cnt <= acc_cnt + 4'd1;
               end
            end
            S_CMD_WAIT: begin
               if (bus.FRW) begin
                  done  <= gnt;
                  state <= S_DONE;
               end else if (wait_cnt == TO_LAST) begin
                  done  <= gnt;
                  err   <= 1'b1;
                  state <= S_DONE;
               end else if (wait_cnt != 8'hFF) begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
`endif
            S_DONE: begin
               gnt   <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
